// File: rtl/irq_pkg.sv
// Shared types and sizes for the 4-source interrupt front end.
package irq_pkg;
  localparam int N_SRC = 4;
  localparam int ID_W  = 2;

  typedef enum logic {IDLE, PRESENT} irq_state_e;
  typedef logic [N_SRC-1:0] irq_vec_t;
endpackage

// File: rtl/priority_encoder.sv
// Fixed-priority encoder: highest set index wins; all-zero input yields 0.
module priority_encoder
  import irq_pkg::*;
(
  input  irq_vec_t          req,
  output logic [ID_W-1:0]   idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N_SRC; i++)
      if (req[i]) idx = ID_W'(i);
  end

endmodule

// File: rtl/irq_pending_capture.sv
// Interrupt front end: sync, edge/level capture, pending + sticky overflow,
// masked selection and a held valid/ready presentation of one source ID.
module irq_pending_capture
  import irq_pkg::*;
#(
  parameter int       SYNC_STAGES = 2,
  parameter irq_vec_t EDGE_MODE   = 4'b1111
) (
  input  logic            clk,
  input  logic            rst_n,
  input  irq_vec_t        irq_in,
  input  irq_vec_t        irq_mask,
  output logic            irq_valid,
  output logic [ID_W-1:0] irq_id,
  input  logic            irq_ready,
  output irq_vec_t        pending,
  output irq_vec_t        overflow,
  input  irq_vec_t        ovf_clr
);

  irq_vec_t        sync, sync_q, edge_det, pend_nxt, ovf_nxt, req;
  logic [ID_W-1:0] winner;
  logic            hs;
  irq_state_e      state_q, state_d;

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) chain <= '0;
      else        chain <= {chain[SYNC_STAGES-2:0], irq_in[i]};
    assign sync[i] = chain[SYNC_STAGES-1];
  end

  assign edge_det = sync & ~sync_q;
  assign hs       = irq_valid & irq_ready;

  // Edge sources: a new edge beats a same-cycle clear, and only counts as
  // lost when the bit is already pending and is not being consumed now.
  always_comb begin
    pend_nxt = pending;
    ovf_nxt  = overflow & ~ovf_clr;
    for (int i = 0; i < N_SRC; i++) begin
      if (EDGE_MODE[i]) begin
        if (edge_det[i]) begin
          pend_nxt[i] = 1'b1;
          if (pending[i] && !(hs && irq_id == ID_W'(i))) ovf_nxt[i] = 1'b1;
        end else if (hs && irq_id == ID_W'(i)) begin
          pend_nxt[i] = 1'b0;
        end
      end else begin
        pend_nxt[i] = sync[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q   <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      sync_q   <= sync;
      pending  <= pend_nxt;
      overflow <= ovf_nxt;
    end

  assign req = pending & ~irq_mask;

  priority_encoder u_prio (
    .req (req),
    .idx (winner)
  );

  // irq_id is captured once on entry to PRESENT and frozen until accepted.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      irq_id  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req != '0) irq_id <= winner;
    end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req != '0) state_d = PRESENT;
      PRESENT: if (irq_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb irq_valid = (state_q == PRESENT);

endmodule
